// File: rtl/wb_scoreboard.sv
// Writeback scoreboard for the RV32I core.
// A shadow register file follows the in-order issue stream. Each decoded
// instruction with rd != 0 queues an {rd, value} expectation. The core's
// writebacks are then compared against that queue in strict order.
module wb_scoreboard #(
  parameter int XLEN             = 32,
  parameter int DEPTH            = 8,
  parameter int STOP_ON_MISMATCH = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   issue_valid,
  output logic                   issue_ready,
  input  logic [31:0]            issue_instr,
  input  logic                   wb_valid,
  input  logic [4:0]             wb_rd,
  input  logic [XLEN-1:0]        wb_data,
  output logic                   mismatch,
  output logic [4:0]             mismatch_rd,
  output logic [XLEN-1:0]        mismatch_exp,
  output logic [XLEN-1:0]        mismatch_got,
  output logic [15:0]            match_count,
  output logic [15:0]            err_count,
  output logic [15:0]            unsupported_count,
  output logic [$clog2(DEPTH):0] pending,
  output logic                   unexpected_wb,
  output logic                   halted
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  // Instruction fields
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic [4:0] rs2;

  assign opcode = issue_instr[6:0];
  assign rd     = issue_instr[11:7];
  assign funct3 = issue_instr[14:12];
  assign rs1    = issue_instr[19:15];
  assign rs2    = issue_instr[24:20];
  assign funct7 = issue_instr[31:25];

  // Shadow register file. Entry 0 is never written, so it stays at its reset value of 0.
  logic [XLEN-1:0] shadow_q [32];

  // Expectation FIFO storage. The contents need no reset because the pointers and count define validity.
  logic [4:0]      fifo_rd_mem   [DEPTH];
  logic [XLEN-1:0] fifo_data_mem [DEPTH];

  // Registered state
  logic            issue_ready_q, issue_ready_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   count_q, count_d;
  logic [15:0]     match_q, match_d;
  logic [15:0]     err_q, err_d;
  logic [15:0]     unsup_q, unsup_d;
  logic            unexp_q, unexp_d;
  logic            halted_q, halted_d;
  logic            mismatch_q, mismatch_d;
  logic [4:0]      mm_rd_q, mm_rd_d;
  logic [XLEN-1:0] mm_exp_q, mm_exp_d;
  logic [XLEN-1:0] mm_got_q, mm_got_d;

  // Operands and decode result
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [XLEN-1:0] imm_val;
  logic [XLEN-1:0] lui_val;
  logic            dec_ok;
  logic [XLEN-1:0] dec_val;

  assign rs1_val = shadow_q[rs1];
  assign rs2_val = shadow_q[rs2];
  // Sign-extending casts also truncate correctly when XLEN is below 32
  assign imm_val = XLEN'($signed(issue_instr[31:20]));
  assign lui_val = XLEN'($signed({issue_instr[31:12], 12'b0}));

  // Handshake and queue control
  logic            accept;
  logic            wb_fire;
  logic            fifo_empty;
  logic            push;
  logic            pop;
  logic            hit;
  logic            miss;
  logic [4:0]      head_rd;
  logic [XLEN-1:0] head_data;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Decode the offered instruction and compute its result from the current shadow file
  always_comb begin
    dec_ok  = 1'b0;
    dec_val = '0;
    case (opcode)
      7'b0010011: begin
        dec_ok = 1'b1;
        case (funct3)
          3'b000:  dec_val = rs1_val + imm_val;
          3'b100:  dec_val = rs1_val ^ imm_val;
          3'b110:  dec_val = rs1_val | imm_val;
          3'b111:  dec_val = rs1_val & imm_val;
          default: dec_ok  = 1'b0;
        endcase
      end
      7'b0110011: begin
        if (funct7 == 7'b0000000) begin
          dec_ok = 1'b1;
          case (funct3)
            3'b000:  dec_val = rs1_val + rs2_val;
            3'b100:  dec_val = rs1_val ^ rs2_val;
            3'b110:  dec_val = rs1_val | rs2_val;
            3'b111:  dec_val = rs1_val & rs2_val;
            default: dec_ok  = 1'b0;
          endcase
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          dec_ok  = 1'b1;
          dec_val = rs1_val - rs2_val;
        end
      end
      7'b0110111: begin
        dec_ok  = 1'b1;
        dec_val = lui_val;
      end
      default: ;
    endcase
  end

  // The writeback compares against the pre-push FIFO head.
  // A same-cycle push into an empty queue is therefore not visible to it.
  always_comb begin
    accept     = issue_valid && issue_ready_q;
    wb_fire    = wb_valid && (wb_rd != 5'd0) && !halted_q;
    fifo_empty = (count_q == '0);
    push       = accept && dec_ok && (rd != 5'd0);
    pop        = wb_fire && !fifo_empty;
    head_rd    = fifo_rd_mem[rd_ptr_q];
    head_data  = fifo_data_mem[rd_ptr_q];
    hit        = pop && (head_rd == wb_rd) && (head_data == wb_data);
    miss       = pop && !hit;
  end

  // Next-state for counters, pointers, flags and the mismatch report
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    match_d    = match_q;
    err_d      = err_q;
    unsup_d    = unsup_q;
    unexp_d    = unexp_q;
    halted_d   = halted_q;
    mismatch_d = 1'b0;
    mm_rd_d    = mm_rd_q;
    mm_exp_d   = mm_exp_q;
    mm_got_d   = mm_got_q;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + PW'(1);
      2'b01:   count_d = count_q - PW'(1);
      default: count_d = count_q;
    endcase

    if (hit) match_d = sat_inc(match_q);
    if (miss || (wb_fire && fifo_empty)) err_d = sat_inc(err_q);
    if (wb_fire && fifo_empty) unexp_d = 1'b1;
    if (accept && !dec_ok) unsup_d = sat_inc(unsup_q);

    if (miss) begin
      mismatch_d = 1'b1;
      mm_rd_d    = head_rd;
      mm_exp_d   = head_data;
      mm_got_d   = wb_data;
      if (STOP_ON_MISMATCH != 0) halted_d = 1'b1;
    end

    // Ready is registered so that it reads 0 throughout reset and rises on the first edge after reset
    issue_ready_d = (count_d != PW'(DEPTH)) && !halted_d;
  end

  // Control and status registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      issue_ready_q <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      match_q       <= '0;
      err_q         <= '0;
      unsup_q       <= '0;
      unexp_q       <= 1'b0;
      halted_q      <= 1'b0;
      mismatch_q    <= 1'b0;
      mm_rd_q       <= '0;
      mm_exp_q      <= '0;
      mm_got_q      <= '0;
    end else begin
      issue_ready_q <= issue_ready_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      match_q       <= match_d;
      err_q         <= err_d;
      unsup_q       <= unsup_d;
      unexp_q       <= unexp_d;
      halted_q      <= halted_d;
      mismatch_q    <= mismatch_d;
      mm_rd_q       <= mm_rd_d;
      mm_exp_q      <= mm_exp_d;
      mm_got_q      <= mm_got_d;
    end
  end

  // Shadow register write on every queued expectation (rd is never 0 here)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) shadow_q[i] <= '0;
    end else if (push) begin
      shadow_q[rd] <= dec_val;
    end
  end

  // Expectation FIFO write port
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd_mem[wr_ptr_q]   <= rd;
      fifo_data_mem[wr_ptr_q] <= dec_val;
    end
  end

  assign issue_ready       = issue_ready_q;
  assign mismatch          = mismatch_q;
  assign mismatch_rd       = mm_rd_q;
  assign mismatch_exp      = mm_exp_q;
  assign mismatch_got      = mm_got_q;
  assign match_count       = match_q;
  assign err_count         = err_q;
  assign unsupported_count = unsup_q;
  assign pending           = count_q;
  assign unexpected_wb     = unexp_q;
  assign halted            = halted_q;

endmodule
